uart_tx_fifo: RTL and testbench

Parametrised RS-232 transmitter that supersedes the fixed 8N1/115200 transmitter. It adds configurable baud divisor, data width, parity and stop bits. A small transmit FIFO with a ready/send handshake allows back-to-back frames, and a sticky overflow flag can be cleared. It sits between the host/debug logic and the board UART TX pin.

---
 rtl/uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Parametrised RS-232 transmitter with a small transmit FIFO. Host logic
// writes words with a ready/send handshake. The serialiser drains the FIFO
// and sends frames back-to-back when more words are waiting. A sticky
// overflow flag records any write attempted while the FIFO was full.
//
// Frame layout on uart_tx (idle high):
//   start (0) | DATA_BITS data, LSB first | optional parity | STOP_BITS stops (1)
// Every bit lasts exactly CLK_DIV clock cycles.
//
// Parameters:
//   CLK_DIV     clock cycles per serial bit (>= 2)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   number of stop bits (1 or 2)
//   FIFO_DEPTH  transmit FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active-low
//   data        word to transmit
//   send        write strobe; the word is accepted when send && ready
//   ready       FIFO not full (derived from the registered count)
//   uart_tx     registered serial output, idle high
//   busy        FIFO non-empty or a frame in progress
//   fifo_count  number of entries currently queued
//   uart_ovf    sticky overflow flag, set by send && !ready
//   ovf_clr     clears uart_ovf (a simultaneous set takes priority)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLK_DIV    = 100,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          data,
   input  logic                          send,
   output logic                          ready,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          uart_ovf,
   input  logic                          ovf_clr
);

   // Pointer, count, divider and bit-counter widths
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 push;
   logic                 pop;
   logic                 empty;
   logic [DATA_BITS-1:0] head;
   logic                 head_parity;

   // Serialiser state
   tx_state_t            state;
   tx_state_t            state_n;
   logic [DW-1:0]        div_cnt;
   logic [DW-1:0]        div_n;
   logic [BW-1:0]        bit_cnt;
   logic [BW-1:0]        bit_n;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_n;
   logic                 par_bit;
   logic                 par_n;
   logic                 tx_reg;
   logic                 tx_n;
   logic                 bit_done;

   // Overflow flag
   logic                 ovf_reg;

   // The handshake is judged on the registered count only, so a write while
   // full is refused even if the serialiser happens to pop in that cycle.
   assign ready = (count != FULL_COUNT);
   assign empty = (count == '0);
   assign push  = send && ready;

   // The head word and its parity bit are computed here so that the parity
   // can be latched together with the word when the serialiser pops it.
   assign head        = mem[rd_ptr];
   assign head_parity = (PARITY == 1) ? ~(^head) : (^head);

   // The last cycle of each bit time is when the serialiser moves on.
   assign bit_done = (div_cnt == DIV_LAST);

   // FIFO storage: written on every accepted word. The array holds no reset
   // because emptiness is tracked purely through the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data;
      end
   end

   // FIFO pointers and occupancy. Pointers wrap naturally because the depth
   // is a power of two. A push and pop in the same cycle cancel out in the
   // count while both pointers still advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag. A refused write sets it, and setting takes
   // priority over a clear that lands in the same cycle so that no overflow
   // event can be lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else if (send && !ready) begin
         ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
         ovf_reg <= 1'b0;
      end
   end

   // Serialiser state register. uart_tx is registered here so the line never
   // glitches. A reset mid-frame returns the line high on that same edge and
   // abandons the frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         tx_reg  <= 1'b1;
      end else begin
         state   <= state_n;
         div_cnt <= div_n;
         bit_cnt <= bit_n;
         shift   <= shift_n;
         par_bit <= par_n;
         tx_reg  <= tx_n;
      end
   end

   // Serialiser next-state logic. The value placed in tx_n on each transition
   // is the level of the first cycle of the bit being entered. This is why
   // the start bit appears one edge after the word is seen in the FIFO, and
   // why every bit lasts exactly CLK_DIV cycles. Leaving STOP with another
   // word waiting pops it directly into START, so there is no idle gap.
   always_comb begin
      state_n = state;
      div_n   = bit_done ? '0 : div_cnt + 1'b1;
      bit_n   = bit_cnt;
      shift_n = shift;
      par_n   = par_bit;
      tx_n    = tx_reg;
      pop     = 1'b0;

      case (state)
         ST_IDLE: begin
            div_n = '0;
            bit_n = '0;
            tx_n  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               par_n   = head_parity;
               tx_n    = 1'b0;
               state_n = ST_START;
            end
         end

         ST_START: begin
            if (bit_done) begin
               bit_n   = '0;
               tx_n    = shift[0];
               state_n = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_done) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_n = '0;
                  if (PARITY != 0) begin
                     tx_n    = par_bit;
                     state_n = ST_PARITY;
                  end else begin
                     tx_n    = 1'b1;
                     state_n = ST_STOP;
                  end
               end else begin
                  bit_n   = bit_cnt + 1'b1;
                  shift_n = shift >> 1;
                  tx_n    = shift[1];
               end
            end
         end

         ST_PARITY: begin
            if (bit_done) begin
               bit_n   = '0;
               tx_n    = 1'b1;
               state_n = ST_STOP;
            end
         end

         ST_STOP: begin
            tx_n = 1'b1;
            if (bit_done) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_n = '0;
                  if (!empty) begin
                     pop     = 1'b1;
                     shift_n = head;
                     par_n   = head_parity;
                     tx_n    = 1'b0;
                     state_n = ST_START;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end
         end

         default: begin
            div_n   = '0;
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = ST_IDLE;
         end
      endcase
   end

   // Output assignments. busy covers both queued words and the frame on the
   // wire, so it drops one cycle after the last stop bit when nothing waits.
   assign uart_tx    = tx_reg;
   assign busy       = (state != ST_IDLE) || (count != '0);
   assign fifo_count = count;
   assign uart_ovf   = ovf_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo. Three instances share one clock and
// reset:
//   dut0: 8 data bits, no parity, 1 stop bit
//   dut1: 7 data bits, even parity, 1 stop bit
//   dut2: 7 data bits, odd parity, 2 stop bits
// All three use CLK_DIV=4 and FIFO_DEPTH=4. Only one instance is exercised
// at a time, selected by 'sel'.
//
// Every accepted word is pushed into a queue when it is driven. A serial
// monitor samples the selected line once per cycle and decodes each frame.
// It then pops the oldest queued word and compares the full bit pattern
// against a model frame built from that word.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int CLK = 4;

   typedef struct {
      int         sel;
      logic [8:0] word;
      logic       exp_par;
      int         exp_busy;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [8:0]  data_w [3];
   logic [2:0]  send_v;
   logic [2:0]  ovf_clr_v;
   logic [2:0]  ready_v;
   logic [2:0]  tx_v;
   logic [2:0]  busy_v;
   logic [2:0]  ovf_v;
   logic [2:0]  count_v [3];

   int          checks;
   int          failures;
   int          cyc;
   int          sel;
   logic        abort_mon;
   int          frames;
   int          b2b;
   int          last_end;
   logic        last_par;
   logic [8:0]  expq [$];

   int          dbits_cfg [3] = '{8, 7, 7};
   int          par_cfg   [3] = '{0, 2, 1};
   int          stop_cfg  [3] = '{1, 1, 2};

   vec_t        vecs [10];

   uart_tx_fifo #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data_w[0][7:0]),
      .send       (send_v[0]),
      .ready      (ready_v[0]),
      .uart_tx    (tx_v[0]),
      .busy       (busy_v[0]),
      .fifo_count (count_v[0]),
      .uart_ovf   (ovf_v[0]),
      .ovf_clr    (ovf_clr_v[0])
   );

   uart_tx_fifo #(.CLK_DIV(CLK), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data_w[1][6:0]),
      .send       (send_v[1]),
      .ready      (ready_v[1]),
      .uart_tx    (tx_v[1]),
      .busy       (busy_v[1]),
      .fifo_count (count_v[1]),
      .uart_ovf   (ovf_v[1]),
      .ovf_clr    (ovf_clr_v[1])
   );

   uart_tx_fifo #(.CLK_DIV(CLK), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data_w[2][6:0]),
      .send       (send_v[2]),
      .ready      (ready_v[2]),
      .uart_tx    (tx_v[2]),
      .busy       (busy_v[2]),
      .fifo_count (count_v[2]),
      .uart_ovf   (ovf_v[2]),
      .ovf_clr    (ovf_clr_v[2])
   );

   // Free-running clock and a cycle counter used to timestamp frames
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Compare one value and report any difference
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Raise send with a word for one edge; queue it if it should be accepted.
   // Returns at the negedge after the sampling edge with send still high.
   task automatic applyStimulus(input int s, input logic [8:0] w, input logic accept);
      data_w[s] = w;
      send_v[s] = 1'b1;
      if (accept) expq.push_back(w);
      @(negedge clk);
   endtask

   // Reference frame: bit 0 is the start bit, unused upper bits stay high
   function automatic logic [15:0] expBits(input logic [8:0] w, input int db, input int p);
      logic [15:0] f;
      logic        x;
      f    = '1;
      f[0] = 1'b0;
      x    = 1'b0;
      for (int i = 0; i < db; i++) begin
         f[1+i] = w[i];
         x      = x ^ w[i];
      end
      if (p != 0) f[1+db] = (p == 2) ? x : ~x;
      return f;
   endfunction

   // Sample one frame cycle by cycle starting on its first start-bit cycle;
   // each bit must hold steady for CLK cycles.
   task automatic receiveFrame();
      int          nb;
      int          s0;
      int          gap;
      logic [15:0] rx;
      logic        glitch;
      logic        v;
      logic [8:0]  w;
      nb     = 1 + dbits_cfg[sel] + ((par_cfg[sel] != 0) ? 1 : 0) + stop_cfg[sel];
      s0     = cyc;
      rx     = '1;
      glitch = 1'b0;
      for (int k = 0; k < nb * CLK; k++) begin
         if (k > 0) @(negedge clk);
         if (abort_mon) return;
         v = tx_v[sel];
         if (k % CLK == 0) rx[k/CLK] = v;
         else if (v !== rx[k/CLK]) glitch = 1'b1;
      end
      gap      = s0 - last_end - 1;
      last_end = cyc;
      if (gap == 0) b2b++;
      frames++;
      last_par = rx[1 + dbits_cfg[sel]];
      if (expq.size() == 0) begin
         checkOutput("unexpected_frame", rx, 32'h0);
      end else begin
         w = expq.pop_front();
         checkOutput("frame_bits", rx, expBits(w, dbits_cfg[sel], par_cfg[sel]));
         checkOutput("frame_stable", glitch, 1'b0);
      end
   endtask

   // Serial monitor on the selected instance
   initial begin
      forever begin
         @(negedge clk);
         if (!abort_mon && rst_n && tx_v[sel] === 1'b0) receiveFrame();
      end
   end

   // One isolated send: measure start-bit latency and busy duration
   task automatic runVector(input vec_t v);
      int first_low;
      int bcnt;
      sel = v.sel;
      applyStimulus(v.sel, v.word, 1'b1);
      send_v[v.sel] = 1'b0;
      first_low = -1;
      bcnt      = 0;
      for (int i = 0; i < 300; i++) begin
         if (tx_v[v.sel] === 1'b0 && first_low < 0) first_low = i;
         if (busy_v[v.sel] === 1'b1) bcnt++;
         else break;
         @(negedge clk);
      end
      checkOutput("start_latency", first_low, 1);
      checkOutput("busy_cycles", bcnt, v.exp_busy);
      if (par_cfg[v.sel] != 0) checkOutput("parity_bit", last_par, v.exp_par);
   endtask

   // Wait for the selected instance to go idle within a cycle budget
   task automatic waitIdle(input int s, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (busy_v[s] === 1'b0) break;
         @(negedge clk);
      end
      checkOutput(name, busy_v[s], 1'b0);
   endtask

   initial begin
      int f0;
      int b0;
      int lows;
      int busys;

      vecs[0] = '{0, 9'h055, 1'b0, 41};
      vecs[1] = '{0, 9'h0A3, 1'b0, 41};
      vecs[2] = '{0, 9'h000, 1'b0, 41};
      vecs[3] = '{0, 9'h0FF, 1'b0, 41};
      vecs[4] = '{1, 9'h007, 1'b1, 41};
      vecs[5] = '{1, 9'h000, 1'b0, 41};
      vecs[6] = '{1, 9'h07F, 1'b1, 41};
      vecs[7] = '{2, 9'h007, 1'b0, 45};
      vecs[8] = '{2, 9'h07F, 1'b0, 45};
      vecs[9] = '{2, 9'h000, 1'b1, 45};

      checks    = 0;
      failures  = 0;
      cyc       = 0;
      sel       = 0;
      abort_mon = 1'b0;
      frames    = 0;
      b2b       = 0;
      last_end  = -100;
      last_par  = 1'b0;
      send_v    = '0;
      ovf_clr_v = '0;
      for (int i = 0; i < 3; i++) data_w[i] = '0;
      rst_n = 1'b0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput("reset_tx", tx_v[i], 1'b1);
         checkOutput("reset_busy", busy_v[i], 1'b0);
         checkOutput("reset_ready", ready_v[i], 1'b1);
         checkOutput("reset_count", count_v[i], 3'd0);
         checkOutput("reset_ovf", ovf_v[i], 1'b0);
      end

      $display("[TB] single-frame vectors");
      for (int i = 0; i < 10; i++) begin
         runVector(vecs[i]);
         repeat (3) @(negedge clk);
      end

      $display("[TB] FIFO fill and overflow");
      sel = 0;
      f0  = frames;
      b0  = b2b;
      applyStimulus(0, 9'h011, 1'b1);
      send_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("fifo_drained_head", count_v[0], 3'd0);
      applyStimulus(0, 9'h021, 1'b1);
      applyStimulus(0, 9'h032, 1'b1);
      applyStimulus(0, 9'h043, 1'b1);
      checkOutput("count_3", count_v[0], 3'd3);
      checkOutput("ready_at_3", ready_v[0], 1'b1);
      applyStimulus(0, 9'h054, 1'b1);
      checkOutput("ready_full", ready_v[0], 1'b0);
      checkOutput("count_full", count_v[0], 3'd4);
      checkOutput("ovf_before", ovf_v[0], 1'b0);
      applyStimulus(0, 9'h065, 1'b0);
      checkOutput("ovf_set", ovf_v[0], 1'b1);
      checkOutput("count_after_drop", count_v[0], 3'd4);
      ovf_clr_v[0] = 1'b1;
      applyStimulus(0, 9'h076, 1'b0);
      checkOutput("ovf_set_wins", ovf_v[0], 1'b1);
      send_v[0] = 1'b0;
      @(negedge clk);
      checkOutput("ovf_cleared", ovf_v[0], 1'b0);
      ovf_clr_v[0] = 1'b0;
      waitIdle(0, 400, "fifo_drain_timeout");
      checkOutput("fifo_frames", frames - f0, 5);
      checkOutput("fifo_back_to_back", b2b - b0, 4);
      repeat (3) @(negedge clk);

      $display("[TB] two stop bits with a queued word");
      sel = 2;
      f0  = frames;
      b0  = b2b;
      applyStimulus(2, 9'h015, 1'b1);
      applyStimulus(2, 9'h06A, 1'b1);
      send_v[2] = 1'b0;
      checkOutput("stop2_count", count_v[2], 3'd1);
      waitIdle(2, 200, "stop2_timeout");
      checkOutput("stop2_frames", frames - f0, 2);
      checkOutput("stop2_back_to_back", b2b - b0, 1);
      repeat (3) @(negedge clk);

      $display("[TB] reset mid-frame");
      sel = 0;
      applyStimulus(0, 9'h0C3, 1'b1);
      applyStimulus(0, 9'h0D4, 1'b1);
      applyStimulus(0, 9'h0E5, 1'b1);
      send_v[0] = 1'b0;
      checkOutput("rst_queued", count_v[0], 3'd2);
      repeat (10) @(negedge clk);
      abort_mon = 1'b1;
      rst_n     = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_tx", tx_v[0], 1'b1);
      checkOutput("rst_mid_count", count_v[0], 3'd0);
      checkOutput("rst_mid_busy", busy_v[0], 1'b0);
      rst_n = 1'b1;
      expq.delete();
      lows  = 0;
      busys = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_v[0] !== 1'b1) lows++;
         if (busy_v[0] !== 1'b0) busys++;
      end
      checkOutput("rst_no_frames", lows, 0);
      checkOutput("rst_stays_idle", busys, 0);
      abort_mon = 1'b0;
      runVector('{0, 9'h03C, 1'b0, 41});

      checkOutput("scoreboard_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
